// File: rtl/sum_msg_formatter.sv
// Serialises one captured addition result as "A+B=SS" (optionally CR LF) into uart_tx,
// one byte per transmitter busy cycle, with a single done pulse per message.
module sum_msg_formatter #(
  parameter bit WITH_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [4:0] sum,
  input  logic       uart_tx_busy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, SEND, HOLD, WAIT, DONE} state_t;

  localparam logic [2:0] LAST_IDX = WITH_CRLF ? 3'd7 : 3'd5;

  state_t     state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic [7:0] data_reg, data_next;
  logic [3:0] a_reg, b_reg;
  logic [4:0] sum_reg;
  logic       capture;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n <= 4'd9) hex_char = 8'h30 + {4'h0, n};
    else           hex_char = 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [3:0] op_a,
                                          input logic [3:0] op_b, input logic [4:0] s);
    logic [1:0] tens;
    logic [4:0] ones;
    if      (s >= 5'd30) tens = 2'd3;
    else if (s >= 5'd20) tens = 2'd2;
    else if (s >= 5'd10) tens = 2'd1;
    else                 tens = 2'd0;
    // ones = s - 10*tens, with 10*tens built as 8*tens + 2*tens
    ones = s - {tens, 3'b000} - {2'b00, tens, 1'b0};
    case (idx)
      3'd0:    msg_byte = hex_char(op_a);
      3'd1:    msg_byte = 8'h2B;
      3'd2:    msg_byte = hex_char(op_b);
      3'd3:    msg_byte = 8'h3D;
      3'd4:    msg_byte = 8'h30 + {6'b0, tens};
      3'd5:    msg_byte = 8'h30 + {3'b0, ones};
      3'd6:    msg_byte = 8'h0D;
      default: msg_byte = 8'h0A;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= 3'd0;
      data_reg  <= 8'h00;
      a_reg     <= 4'h0;
      b_reg     <= 4'h0;
      sum_reg   <= 5'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      if (capture) begin
        a_reg   <= a;
        b_reg   <= b;
        sum_reg <= sum;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    capture    = 1'b0;
    uart_tx_en = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          idx_next   = 3'd0;
          // first byte comes straight from the operands being captured this edge
          data_next  = msg_byte(3'd0, a, b, sum);
          state_next = SEND;
        end
      end
      SEND: begin
        if (!uart_tx_busy) begin
          uart_tx_en = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: state_next = WAIT;
      WAIT: begin
        if (!uart_tx_busy) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 3'd1;
            data_next  = msg_byte(idx_reg + 3'd1, a_reg, b_reg, sum_reg);
            state_next = SEND;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign uart_tx_data = data_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);

endmodule

// File: doc/sum_msg_formatter.md
# sum_msg_formatter

Formats one addition result as an ASCII line and feeds it, one byte at a time, into the UART transmitter. The block sits between the latch/adder stage and `uart_tx`. On a `start` pulse it snapshots the operands and the 5-bit sum, then emits `A+B=SS` followed by CR LF. It drives `uart_tx_en`/`uart_tx_data` with a busy-aware handshake, so each result goes out exactly once instead of streaming continuously.

## Interface
- `WITH_CRLF`, default 1: 1 = append 0x0D 0x0A (8-byte message); 0 = 6-byte message.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request to send one message; sampled only in IDLE.
- `a` in 4: operand A (0–15).
- `b` in 4: operand B (0–15).
- `sum` in 5: a+b from the adder (0–30).
- `uart_tx_busy` in 1: transmitter busy flag from `uart_tx`.
- `uart_tx_en` out 1: one-cycle byte strobe to `uart_tx`.
- `uart_tx_data` out 8: byte presented to `uart_tx`; registered.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse after the last byte's transmission completes.

## Operation
- States: IDLE, SEND, HOLD, WAIT, DONE.
- IDLE, `start`=1:
  - capture `a`, `b`, `sum` into internal registers;
  - byte index ← 0;
  - next state SEND.
- IDLE, `start`=0: stay in IDLE.
- `start` is ignored in every state other than IDLE.
- SEND:
  - `uart_tx_data` = byte[index], computed from the captured registers only;
  - if `uart_tx_busy`=0: `uart_tx_en`=1 for this cycle, then go to HOLD;
  - else stay in SEND with `uart_tx_en`=0.
- HOLD: exactly one cycle, `uart_tx_en`=0. This covers the one-cycle latency before `uart_tx` raises busy. Then go to WAIT.
- WAIT: stay while `uart_tx_busy`=1. When it is 0:
  - if index = last: go to DONE;
  - else index+1 and go to SEND.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Byte sequence:
  - 0: hex(A)
  - 1: 0x2B '+'
  - 2: hex(B)
  - 3: 0x3D '='
  - 4: tens(S)
  - 5: ones(S)
  - 6: 0x0D
  - 7: 0x0A
- last = 7 when `WITH_CRLF`=1, 5 otherwise.
- hex(n): n ≤ 9 → 0x30+n; n ≥ 10 → 0x41+(n−10), uppercase.
- Decimal sum, always two digits:
  - tens = 3 if S ≥ 30, 2 if S ≥ 20, 1 if S ≥ 10, else 0;
  - ones = S − 10·tens;
  - tens char = 0x30+tens; ones char = 0x30+ones.
- Captured `sum` is used verbatim; it is not recomputed from A+B.
- Inputs changing after capture have no effect on the message in flight.
- `uart_tx_data` holds its value from SEND through WAIT. It changes only when entering SEND for the next byte.

## Timing
- Reset values: state IDLE, `uart_tx_en`=0, `uart_tx_data`=0x00, `busy`=0, `done`=0, index=0, captured registers=0.
- Reset has priority over all other conditions, including mid-message.
  - The message is abandoned at the next edge; outputs return to reset values.
  - A byte already strobed into `uart_tx` is not recalled.
- Start latency:
  - `start` high in IDLE at edge k → SEND during cycle k+1;
  - with `uart_tx_busy`=0, `uart_tx_en`=1 during cycle k+1;
  - `busy` is high from cycle k+1.
- Per-byte minimum: 3 cycles of formatter overhead (SEND, HOLD, one WAIT cycle) plus the transmitter busy time.
- `uart_tx_en` is never high in two consecutive cycles. It is never high while `uart_tx_busy`=1.
- Busy stuck low after a strobe: WAIT exits on the first cycle after HOLD; no deadlock.
- `done` pulses during the DONE cycle; `busy` is still 1 in that cycle. IDLE follows, where a new `start` is accepted.
- `start` held continuously high: a new message begins on the cycle after DONE.

## Test plan
Bench model of `uart_tx`: busy rises the cycle after `uart_tx_en` and stays high 10 cycles.
- a=3, b=4, sum=7, start pulse → bytes 0x33 0x2B 0x34 0x3D 0x30 0x37 0x0D 0x0A in order, then a single `done` pulse.
- a=F, b=F, sum=30 → 0x46 0x2B 0x46 0x3D 0x33 0x30 0x0D 0x0A. Repeat with a=A, b=0, sum=10 → 0x41 0x2B 0x30 0x3D 0x31 0x30 0x0D 0x0A.
- Start with a=1, b=2, sum=3. Change to a=9, b=9, sum=18 and pulse `start` again during byte 2 → first message unchanged ("1+2=03\r\n"); second start ignored; exactly one `done`.
- Hold `uart_tx_busy`=1 for 20 cycles after start → `uart_tx_en` stays 0 throughout. On release, the strobe fires the same cycle busy is seen low, with data 0x33 for a=3.
- Assert `reset` while WAITing on byte 4 → next cycle: `uart_tx_en`=0, `uart_tx_data`=0x00, `busy`=0, no `done`. A subsequent start sends a full fresh message.
- `WITH_CRLF`=0, a=0, b=0, sum=0 → exactly 6 bytes 0x30 0x2B 0x30 0x3D 0x30 0x30, then `done`.
